quant_block_seq: RTL and testbench

- Time-multiplexed successor to the parallel 16-lane luma quantiser in the reconstruct path.
- One shared quantiser processes NUM_BLK 4x4 sub-blocks streamed one coefficient per cycle: 16 for luma, 8 for chroma u+v, 1 for the WHT DC block.
- Mode input selects full-block quantisation or AC-only, in which raster position 0 is forced to zero.
- Emits levels in zigzag order, dequantised values (Rout) and a per-block nonzero bitmap, with ready/valid flow control on both sides.

---
 rtl/quant_block_seq.sv | 161 ++++++++++++++++
 tb/tb_quant_block_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_block_seq.sv
`default_nettype none
// =====================================================================
// Module  : quant_block_seq
// Brief   : Shared 4x4 block quantiser; raster-order coefficients in,
//           zigzag-order levels / dequantised values out, per-block nz.
// Revision: 1.0
// =====================================================================
module quant_block_seq #(
    parameter int NUM_BLK   = 16,
    parameter int LEVEL_MAX = 2047
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ac_only,
    input  logic [255:0]       q,
    input  logic [255:0]       iq,
    input  logic [511:0]       bias,
    input  logic [511:0]       zthresh,
    input  logic [255:0]       sharpen,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_level,
    output logic [15:0]        out_rout,
    output logic [4:0]         out_blk,
    output logic [3:0]         out_pos,
    output logic [NUM_BLK-1:0] nz,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0]  c_zz [16] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                                          4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};
    localparam logic [16:0] c_lmax = 17'(LEVEL_MAX);

    state_t      r_state;
    logic [15:0] r_buf [16];
    logic [3:0]  r_wr_j;
    logic [4:0]  r_rd_n;    // next zigzag index to issue; 16 = all issued
    logic [4:0]  r_blk;
    logic        r_ac_only;

    logic [3:0]  w_j;
    logic [15:0] w_coef, w_q, w_iq, w_sharp, w_mag, w_level, w_rout;
    logic [31:0] w_bias, w_zth;
    logic [16:0] w_abs, w_a, w_scaled;
    logic [33:0] w_prod;
    logic        w_load;

    always_comb begin
        w_j      = c_zz[r_rd_n[3:0]];
        w_coef   = r_buf[w_j];
        w_q      = q[{w_j, 4'd0} +: 16];
        w_iq     = iq[{w_j, 4'd0} +: 16];
        w_sharp  = sharpen[{w_j, 4'd0} +: 16];
        w_bias   = bias[{w_j, 5'd0} +: 32];
        w_zth    = zthresh[{w_j, 5'd0} +: 32];
        // 17-bit magnitude so that -32768 maps to +32768
        w_abs    = w_coef[15] ? (17'd0 - {1'b1, w_coef}) : {1'b0, w_coef};
        w_a      = w_abs + {1'b0, w_sharp};
        w_prod   = ({17'd0, w_a} * {18'd0, w_iq}) + {2'd0, w_bias};
        w_scaled = w_prod[33:17];
        w_mag    = '0;
        if (!(r_ac_only && w_j == 4'd0) && ({15'd0, w_a} > w_zth))
            w_mag = (w_scaled > c_lmax) ? c_lmax[15:0] : w_scaled[15:0];
        w_level  = w_coef[15] ? (16'd0 - w_mag) : w_mag;
        w_rout   = w_level * w_q;
        w_load   = !out_valid || out_ready;
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_FILL && in_valid)
            r_buf[r_wr_j] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wr_j    <= '0;
            r_rd_n    <= '0;
            r_blk     <= '0;
            r_ac_only <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_level <= '0;
            out_rout  <= '0;
            out_blk   <= '0;
            out_pos   <= '0;
            nz        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready && out_level != 16'd0)
                nz <= nz | (NUM_BLK'(1) << out_blk);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_FILL;
                        in_ready  <= 1'b1;
                        nz        <= '0;
                        r_blk     <= '0;
                        r_wr_j    <= '0;
                        r_rd_n    <= '0;
                        r_ac_only <= ac_only;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        r_wr_j <= r_wr_j + 4'd1;
                        // raster 0 is already buffered, so zigzag 0 issues on the last write
                        if (r_wr_j == 4'd15) begin
                            r_state   <= ST_DRAIN;
                            in_ready  <= 1'b0;
                            r_rd_n    <= 5'd1;
                            out_valid <= 1'b1;
                            out_level <= w_level;
                            out_rout  <= w_rout;
                            out_blk   <= r_blk;
                            out_pos   <= 4'd0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_load) begin
                        if (r_rd_n != 5'd16) begin
                            r_rd_n    <= r_rd_n + 5'd1;
                            out_valid <= 1'b1;
                            out_level <= w_level;
                            out_rout  <= w_rout;
                            out_blk   <= r_blk;
                            out_pos   <= r_rd_n[3:0];
                        end else begin
                            out_valid <= 1'b0;
                            r_rd_n    <= '0;
                            if (r_blk == 5'(NUM_BLK - 1)) begin
                                r_state <= ST_IDLE;
                                done    <= 1'b1;
                            end else begin
                                r_state  <= ST_FILL;
                                in_ready <= 1'b1;
                                r_blk    <= r_blk + 5'd1;
                                r_wr_j   <= '0;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quant_block_seq.sv
`default_nettype none
// =====================================================================
// Module  : tb_quant_block_seq
// Brief   : Self-checking bench: directed vector table, reset-in-drain
//           sequence and randomised 16-block passes vs. a reference model.
// Revision: 1.0
// =====================================================================
module tb_quant_block_seq;

    localparam int LEVEL_MAX = 2047;
    localparam logic [3:0] c_zz [16] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                                         4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};

    typedef struct {
        logic [15:0] q, iq, sh;
        logic [31:0] bias, zth;
        logic [15:0] din, lvl, rout;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start1, start16, ac_only, in_valid, out_ready, sel;
    logic [15:0] in_data;
    logic [15:0] cfg_q [16], cfg_iq [16], cfg_sh [16];
    logic [31:0] cfg_bias [16], cfg_zth [16];
    logic [255:0] q, iq, sharpen;
    logic [511:0] bias, zthresh;
    logic [15:0] stim [16][16];

    logic        in_ready1, out_valid1, done1;
    logic [15:0] out_level1, out_rout1;
    logic [4:0]  out_blk1;
    logic [3:0]  out_pos1;
    logic [0:0]  nz1;
    logic        in_ready16, out_valid16, done16;
    logic [15:0] out_level16, out_rout16, nz16;
    logic [4:0]  out_blk16;
    logic [3:0]  out_pos16;

    logic        t_in_ready, t_out_valid, t_done;
    logic [15:0] t_level, t_rout, t_nz;
    logic [4:0]  t_blk;
    logic [3:0]  t_pos;

    always_comb begin
        q = '0; iq = '0; sharpen = '0; bias = '0; zthresh = '0;
        for (int j = 0; j < 16; j++) begin
            q[j*16 +: 16]       = cfg_q[j];
            iq[j*16 +: 16]      = cfg_iq[j];
            sharpen[j*16 +: 16] = cfg_sh[j];
            bias[j*32 +: 32]    = cfg_bias[j];
            zthresh[j*32 +: 32] = cfg_zth[j];
        end
    end

    always_comb begin
        t_in_ready  = sel ? in_ready16  : in_ready1;
        t_out_valid = sel ? out_valid16 : out_valid1;
        t_done      = sel ? done16      : done1;
        t_level     = sel ? out_level16 : out_level1;
        t_rout      = sel ? out_rout16  : out_rout1;
        t_blk       = sel ? out_blk16   : out_blk1;
        t_pos       = sel ? out_pos16   : out_pos1;
        t_nz        = sel ? nz16        : {15'd0, nz1};
    end

    quant_block_seq #(.NUM_BLK(1), .LEVEL_MAX(LEVEL_MAX)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ac_only(ac_only),
        .q(q), .iq(iq), .bias(bias), .zthresh(zthresh), .sharpen(sharpen),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_level(out_level1),
        .out_rout(out_rout1), .out_blk(out_blk1), .out_pos(out_pos1),
        .nz(nz1), .done(done1));

    quant_block_seq #(.NUM_BLK(16), .LEVEL_MAX(LEVEL_MAX)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .ac_only(ac_only),
        .q(q), .iq(iq), .bias(bias), .zthresh(zthresh), .sharpen(sharpen),
        .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
        .out_valid(out_valid16), .out_ready(out_ready), .out_level(out_level16),
        .out_rout(out_rout16), .out_blk(out_blk16), .out_pos(out_pos16),
        .nz(nz16), .done(done16));

    int n_tests = 0;
    int n_fail  = 0;
    logic [40:0] got_q [$];
    logic [40:0] exp_q [$];
    int          done_cnt, done_lat;
    logic [15:0] fin_nz;
    vec_t        vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dut1"}, 64'({in_ready1, out_valid1, out_level1, out_rout1,
                                   out_blk1, out_pos1, nz1, done1}), 64'd0);
        check({tag, "_dut16"}, 64'({in_ready16, out_valid16, out_level16, out_rout16,
                                    out_blk16, out_pos16, nz16, done16}), 64'd0);
    endtask

    task automatic set_cfg(input vec_t v);
        for (int j = 0; j < 16; j++) begin
            cfg_q[j] = v.q; cfg_iq[j] = v.iq; cfg_sh[j] = v.sh;
            cfg_bias[j] = v.bias; cfg_zth[j] = v.zth;
        end
    endtask

    // Plain-arithmetic quantiser reference for one raster position
    task automatic ref_q(input int c, input int j, input bit ac, output int lvl, output int rout);
        longint a, v;
        a = longint'(c < 0 ? -c : c) + longint'(cfg_sh[j]);
        lvl = 0;
        if (!(ac && j == 0) && a > longint'(cfg_zth[j])) begin
            v = (a * longint'(cfg_iq[j]) + longint'(cfg_bias[j])) / 131072;
            if (v > LEVEL_MAX) v = LEVEL_MAX;
            lvl = (c < 0) ? -int'(v) : int'(v);
        end
        rout = (lvl * int'(cfg_q[j])) & 32'hFFFF;
    endtask

    task automatic run_pass(input bit s16, input int nblk, input int gap_pct, input int stall_pct);
        int bi = 0, ji = 0, last_in = 0;
        got_q.delete();
        done_cnt = 0; done_lat = -1; fin_nz = '0;
        sel = s16;
        @(posedge clk); #1;
        if (s16) start16 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start16 = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            in_valid  = (bi < nblk) && (int'($urandom_range(99)) >= gap_pct);
            in_data   = (bi < nblk) ? stim[bi][ji] : 16'h0;
            out_ready = int'($urandom_range(99)) >= stall_pct;
            @(negedge clk);
            if (t_done) begin
                done_cnt++; done_lat = cyc - last_in; fin_nz = t_nz;
                break;
            end
            if (in_valid && t_in_ready) begin
                ji++;
                if (ji == 16) begin ji = 0; bi++; last_in = cyc; end
            end
            if (t_out_valid && out_ready) got_q.push_back({t_blk, t_pos, t_level, t_rout});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pass_done", 64'(done_cnt), 64'd1);
    endtask

    task automatic check_single(input string tag, input logic [15:0] lvl,
                                input logic [15:0] rout, input int only_pos);
        logic [40:0] e;
        check({tag, "_count"}, 64'(got_q.size()), 64'd16);
        for (int n = 0; n < 16 && n < got_q.size(); n++) begin
            e = (only_pos < 0 || n == only_pos) ? {5'd0, 4'(n), lvl, rout} : {5'd0, 4'(n), 32'd0};
            check($sformatf("%s_out%0d", tag, n), 64'(got_q[n]), 64'(e));
        end
        check({tag, "_nz"}, 64'(fin_nz), 64'(lvl != 16'd0));
        check({tag, "_done_lat"}, 64'(done_lat), 64'd17);
    endtask

    initial begin
        int lvl, rout;
        logic [15:0] exp_nz;
        rst_n = 1'b0; start1 = 1'b0; start16 = 1'b0; ac_only = 1'b0; sel = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int b = 0; b < 16; b++) for (int j = 0; j < 16; j++) stim[b][j] = '0;

        vecs[0] = '{16'd32, 16'd4096,  16'd0,  32'd0,     32'd0,  16'd100,   16'd3,     16'd96};
        vecs[1] = '{16'd32, 16'd4096,  16'd0,  32'd0,     32'd0,  16'hFF9C,  16'hFFFD,  16'hFFA0};
        vecs[2] = '{16'd32, 16'd4096,  16'd0,  32'd0,     32'd31, 16'd31,    16'd0,     16'd0};
        vecs[3] = '{16'd32, 16'd4096,  16'd0,  32'd0,     32'd31, 16'd32,    16'd1,     16'd32};
        vecs[4] = '{16'd32, 16'd4096,  16'd1,  32'd0,     32'd31, 16'd31,    16'd1,     16'd32};
        vecs[5] = '{16'd32, 16'd65535, 16'd0,  32'd0,     32'd0,  16'd32767, 16'h07FF,  16'hFFE0};
        vecs[6] = '{16'd32, 16'd65535, 16'd0,  32'd0,     32'd0,  16'h8000,  16'hF801,  16'h0020};
        vecs[7] = '{16'd10, 16'd4096,  16'd0,  32'd65536, 32'd0,  16'd16,    16'd1,     16'd10};
        vecs[8] = '{16'd32, 16'd4096,  16'd0,  32'd0,     32'd0,  16'd0,     16'd0,     16'd0};
        vecs[9] = '{16'd10, 16'd4096,  16'd40, 32'd0,     32'd0,  16'd0,     16'd1,     16'd10};
        set_cfg(vecs[0]);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table on the single-block instance, every position identical
        for (int v = 0; v < 10; v++) begin
            set_cfg(vecs[v]);
            for (int j = 0; j < 16; j++) stim[0][j] = vecs[v].din;
            run_pass(1'b0, 1, 0, 0);
            check_single($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].rout, -1);
        end

        // Single nonzero coefficient at raster 4 lands at zigzag 2
        set_cfg(vecs[0]);
        for (int j = 0; j < 16; j++) stim[0][j] = (j == 4) ? 16'hFF9C : 16'd0;
        run_pass(1'b0, 1, 0, 0);
        check_single("zz_pos", 16'hFFFD, 16'hFFA0, 2);

        // Reset held three cycles in the middle of a drain
        for (int j = 0; j < 16; j++) stim[0][j] = 16'd100;
        sel = 1'b1;
        @(posedge clk); #1; start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0;
        out_ready = 1'b0;
        for (int k = 0, cyc = 0; k < 16 && cyc < 100; cyc++) begin
            in_valid = 1'b1; in_data = stim[0][k];
            @(negedge clk);
            if (in_ready16) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("drain_pre_reset", 64'({out_valid16, out_level16, out_pos16}), 64'({1'b1, 16'd3, 4'd2}));
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset_no_done%0d", c), 64'(done16), 64'd0);
            @(posedge clk); #1;
        end
        check_reset_state("mid_drain_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_done", 64'(done16), 64'd0);

        // Randomised 16-block passes with input gaps and output stalls
        for (int rep = 0; rep < 2; rep++) begin
            ac_only = (rep == 0);
            for (int j = 0; j < 16; j++) begin
                cfg_q[j]    = 16'($urandom_range(1, 100));
                cfg_iq[j]   = 16'($urandom_range(0, 8191));
                cfg_sh[j]   = 16'($urandom_range(0, 50));
                cfg_bias[j] = 32'($urandom_range(0, 65535));
                cfg_zth[j]  = 32'($urandom_range(0, 2000));
            end
            for (int b = 0; b < 16; b++)
                for (int j = 0; j < 16; j++)
                    if (b % 4 == 3) stim[b][j] = '0;
                    else if ($urandom_range(3) == 0) stim[b][j] = 16'($urandom);
                    else stim[b][j] = 16'($urandom_range(0, 600)) - 16'd300;
            exp_q.delete();
            exp_nz = '0;
            for (int b = 0; b < 16; b++)
                for (int n = 0; n < 16; n++) begin
                    ref_q(int'($signed(stim[b][c_zz[n]])), int'(c_zz[n]), ac_only, lvl, rout);
                    exp_q.push_back({5'(b), 4'(n), 16'(lvl), 16'(rout)});
                    if (lvl != 0) exp_nz[b] = 1'b1;
                end
            run_pass(1'b1, 16, 30, 40);
            check($sformatf("rand%0d_count", rep), 64'(got_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check($sformatf("rand%0d_out%0d", rep, i), 64'(got_q[i]), 64'(exp_q[i]));
            check($sformatf("rand%0d_nz", rep), 64'(fin_nz), 64'(exp_nz));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
